// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared raster timing constants for the pattern-generator bus.
// The DEF_* values describe 640x480@60 (800x525 totals, 25.175 MHz pixel clock).
// AXIS_W is the width of the x/y/frame_count buses.
// total_fits() is used at elaboration time to reject totals that the
// 10-bit position buses cannot represent.
package vga_timing_pkg;

  localparam int AXIS_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int DEF_HSYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_HSYNC_END   = DEF_HSYNC_START + DEF_H_SYNC - 1;
  localparam int DEF_VSYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_VSYNC_END   = DEF_VSYNC_START + DEF_V_SYNC - 1;

  function automatic bit total_fits(input int total);
    return (total >= 1) && (total <= (1 << AXIS_W));
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// One raster axis: a 0..TOTAL-1 wrap counter with enable, a terminal-count
// flag and a registered window decode.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance the counter this cycle
//   count      : registered position (resets to TOTAL-1, the last blank slot)
//   count_nxt  : value count takes on the next edge (lets the parent register
//                its own decodes in step with count)
//   tc         : count is at TOTAL-1
//   win        : registered decode of WIN_START..WIN_END, XORed with WIN_INVERT;
//                computed from count_nxt so it lines up with count
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = DEF_H_TOTAL,
  parameter int WIN_START  = DEF_HSYNC_START,
  parameter int WIN_END    = DEF_HSYNC_END,
  parameter bit WIN_INVERT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [AXIS_W-1:0] count,
  output logic [AXIS_W-1:0] count_nxt,
  output logic              tc,
  output logic              win
);

  localparam logic [AXIS_W-1:0] LAST = AXIS_W'(TOTAL - 1);
  localparam logic [AXIS_W-1:0] WS   = AXIS_W'(WIN_START);
  localparam logic [AXIS_W-1:0] WE   = AXIS_W'(WIN_END);

  assign tc = (count == LAST);

  always_comb begin
    count_nxt = count;
    if (en) begin
      count_nxt = tc ? '0 : count + AXIS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= LAST;
      win   <= WIN_INVERT;
    end else begin
      count <= count_nxt;
      win   <= ((count_nxt >= WS) && (count_nxt <= WE)) ^ WIN_INVERT;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing producer for the pattern-generator bus.
//   clk, rst_n  : pixel-domain clock, asynchronous active-low reset
//   pix_en      : advance one pixel this cycle
//   x, y        : current raster position
//   active      : position lies in the visible area
//   hsync/vsync : sync pins, asserted low when SYNC_ACTIVE_LOW=1
//   next_frame  : one-clk pulse when the position first reaches (0, V_ACTIVE)
//   frame_count : frames completed since reset, wraps modulo 1024
// Every output is a flop loaded from next-position decodes, so all outputs
// describe the same (x, y) in any cycle.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE        = DEF_H_ACTIVE,
  parameter int H_FP            = DEF_H_FP,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BP            = DEF_H_BP,
  parameter int V_ACTIVE        = DEF_V_ACTIVE,
  parameter int V_FP            = DEF_V_FP,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BP            = DEF_V_BP,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  output logic [AXIS_W-1:0] x,
  output logic [AXIS_W-1:0] y,
  output logic              active,
  output logic              hsync,
  output logic              vsync,
  output logic              next_frame,
  output logic [AXIS_W-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int HSYNC_START = H_ACTIVE + H_FP;
  localparam int HSYNC_END   = HSYNC_START + H_SYNC - 1;
  localparam int VSYNC_START = V_ACTIVE + V_FP;
  localparam int VSYNC_END   = VSYNC_START + V_SYNC - 1;

  localparam logic [AXIS_W-1:0] V_LAST_ACTIVE = AXIS_W'(V_ACTIVE - 1);

  generate
    if (!total_fits(H_TOTAL) || !total_fits(V_TOTAL)) begin : g_bad_totals
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must be in 1..1024");
    end
  endgenerate

  logic [AXIS_W-1:0] x_nxt;
  logic [AXIS_W-1:0] y_nxt;
  logic              h_tc;
  logic              v_tc;
  logic              frame_edge;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .WIN_START  (HSYNC_START),
    .WIN_END    (HSYNC_END),
    .WIN_INVERT (SYNC_ACTIVE_LOW)
  ) u_h (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (pix_en),
    .count     (x),
    .count_nxt (x_nxt),
    .tc        (h_tc),
    .win       (hsync)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .WIN_START  (VSYNC_START),
    .WIN_END    (VSYNC_END),
    .WIN_INVERT (SYNC_ACTIVE_LOW)
  ) u_v (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (pix_en & h_tc),
    .count     (y),
    .count_nxt (y_nxt),
    .tc        (v_tc),
    .win       (vsync)
  );

  // The edge that carries the last pixel of the last visible line into
  // (0, V_ACTIVE). Only a real advance qualifies, so gaps cannot stretch it
  // and the bottom-of-frame wrap never matches.
  assign frame_edge = pix_en && h_tc && (y == V_LAST_ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active      <= 1'b0;
      next_frame  <= 1'b0;
      frame_count <= '0;
    end else begin
      active     <= (32'(x_nxt) < H_ACTIVE) && (32'(y_nxt) < V_ACTIVE);
      next_frame <= frame_edge;
      if (frame_edge) begin
        frame_count <= frame_count + AXIS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  // Instance A: compact active-low timing. Instance B: tiny active-high timing
  // whose 25-cycle frame lets frame_count wrap within the run.
  localparam int HAA = 16, HFA = 2, HSA = 3, HBA = 4;
  localparam int VAA = 10, VFA = 2, VSA = 2, VBA = 3;
  localparam int HTA = HAA + HFA + HSA + HBA;
  localparam int VTA = VAA + VFA + VSA + VBA;
  localparam int FA  = HTA * VTA;

  localparam int HAB = 2, HFB = 1, HSB = 1, HBB = 1;
  localparam int VAB = 2, VFB = 1, VSB = 1, VBB = 1;
  localparam int HTB = HAB + HFB + HSB + HBB;
  localparam int VTB = VAB + VFB + VSB + VBB;
  localparam int FB  = HTB * VTB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_en;
  logic [9:0] xa, ya, fca, xb, yb, fcb;
  logic       acta, hsa, vsa, nfa, actb, hsb, vsb, nfb;

  vga_timing_gen #(
    .H_ACTIVE(HAA), .H_FP(HFA), .H_SYNC(HSA), .H_BP(HBA),
    .V_ACTIVE(VAA), .V_FP(VFA), .V_SYNC(VSA), .V_BP(VBA),
    .SYNC_ACTIVE_LOW(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .x(xa), .y(ya), .active(acta), .hsync(hsa), .vsync(vsa),
    .next_frame(nfa), .frame_count(fca)
  );

  vga_timing_gen #(
    .H_ACTIVE(HAB), .H_FP(HFB), .H_SYNC(HSB), .H_BP(HBB),
    .V_ACTIVE(VAB), .V_FP(VFB), .V_SYNC(VSB), .V_BP(VBB),
    .SYNC_ACTIVE_LOW(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .x(xb), .y(yb), .active(actb), .hsync(hsb), .vsync(vsb),
    .next_frame(nfb), .frame_count(fcb)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a linear pixel index per instance; x/y and all decodes
  // are derived from it arithmetically.
  int pa, fa, pb, fb;
  bit nfa_e, nfb_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit exp_sync(input int c, input int start, input int width, input bit low);
    bit in_w;
    in_w = (c >= start) && (c < start + width);
    return low ? !in_w : in_w;
  endfunction

  task automatic model_reset();
    pa = FA - 1; fa = 0; nfa_e = 0;
    pb = FB - 1; fb = 0; nfb_e = 0;
  endtask

  task automatic check_all();
    chk("a_x", 32'(xa), pa % HTA);
    chk("a_y", 32'(ya), pa / HTA);
    chk("a_active", 32'(acta), 32'((pa % HTA < HAA) && (pa / HTA < VAA)));
    chk("a_hsync", 32'(hsa), 32'(exp_sync(pa % HTA, HAA + HFA, HSA, 1'b1)));
    chk("a_vsync", 32'(vsa), 32'(exp_sync(pa / HTA, VAA + VFA, VSA, 1'b1)));
    chk("a_next_frame", 32'(nfa), 32'(nfa_e));
    chk("a_frame_count", 32'(fca), fa);
    chk("b_x", 32'(xb), pb % HTB);
    chk("b_y", 32'(yb), pb / HTB);
    chk("b_active", 32'(actb), 32'((pb % HTB < HAB) && (pb / HTB < VAB)));
    chk("b_hsync", 32'(hsb), 32'(exp_sync(pb % HTB, HAB + HFB, HSB, 1'b0)));
    chk("b_vsync", 32'(vsb), 32'(exp_sync(pb / HTB, VAB + VFB, VSB, 1'b0)));
    chk("b_next_frame", 32'(nfb), 32'(nfb_e));
    chk("b_frame_count", 32'(fcb), fb);
  endtask

  task automatic step(input bit en);
    pix_en = en;
    @(posedge clk);
    #1;
    nfa_e = 0;
    nfb_e = 0;
    if (rst_n && en) begin
      pa = (pa + 1) % FA;
      if (pa == VAA * HTA) begin
        nfa_e = 1;
        fa = (fa + 1) % 1024;
      end
      pb = (pb + 1) % FB;
      if (pb == VAB * HTB) begin
        nfb_e = 1;
        fb = (fb + 1) % 1024;
      end
    end
    check_all();
  endtask

  initial begin
    int pulses;
    int budget;
    rst_n  = 1'b0;
    pix_en = 1'b0;
    model_reset();
    #12;
    check_all();

    // Free run, three frames from reset: first edge lands on (0,0).
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3 * FA; i++) begin
      step(1'b1);
      if (nfa === 1'b1) pulses++;
    end
    chk("a_pulses_free_run", pulses, 3);

    // pix_en 1,0,0 pattern: three frames of enabled cycles.
    pulses = 0;
    for (int i = 0; i < 9 * FA; i++) begin
      step(i % 3 == 0);
      if (nfa === 1'b1) pulses++;
    end
    chk("a_pulses_gapped", pulses, 3);

    // Random enable pattern.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 3) != 0);
    end

    // Move to a mid-line, mid-frame position, then reset asynchronously.
    budget = FA + 1;
    while (pa != 6 * HTA + 10 && budget > 0) begin
      step(1'b1);
      budget--;
    end
    chk("a_reach_midframe", pa, 6 * HTA + 10);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    step(1'b1);
    step(1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1);
    chk("a_restart_x", 32'(xa), 0);
    chk("a_restart_y", 32'(ya), 0);

    // 1025 frames of instance B: frame_count wraps 1023 -> 0 and lands on 1.
    for (int i = 0; i < 1025 * FB; i++) begin
      step(1'b1);
    end
    chk("b_frame_count_wrapped", 32'(fcb), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
